// File: rtl/delay_ctrl.sv
// Delay line controller: buffers valid beats in a circular RAM and replays each one depth_reg beats later.
// Optional DELAY_CTRL_CNT_EN adds out_count, a wrapping count of emitted beats.
module delay_ctrl #(
    parameter int WIDTH     = 25,
    parameter int MAX_DEPTH = 16,
    parameter int DEF_DEPTH = 7,
    localparam int PTR_W    = $clog2(MAX_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] data_in,
    input  logic                    in_valid,
    input  logic [PTR_W:0]          depth,
    input  logic                    cfg_load,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    out_valid,
    output logic                    cfg_ack,
    output logic                    filling
`ifdef DELAY_CTRL_CNT_EN
    ,
    output logic [15:0]             out_count
`endif
);

    // state | meaning
    // FLUSH | one-cycle restart after a depth change; pointers cleared, cfg_ack high
    // FILL  | collecting depth_reg beats before the first output
    // RUN   | every accepted beat emits the sample depth_reg beats older
    typedef enum logic [1:0] {FLUSH, FILL, RUN} state_t;

    localparam logic [PTR_W:0]   ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   MAXD  = (PTR_W+1)'(MAX_DEPTH);
    localparam logic [PTR_W:0]   DEFD  = (PTR_W+1)'(DEF_DEPTH);
    localparam logic [PTR_W-1:0] W_ONE = PTR_W'(1);
    localparam state_t           RST_STATE = (DEF_DEPTH == 0) ? RUN : FILL;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] mem [MAX_DEPTH];
    logic [PTR_W-1:0]        wptr;
    logic [PTR_W-1:0]        raddr;
    logic [PTR_W:0]          depth_reg;
    logic [PTR_W:0]          fill_cnt;
    logic [PTR_W:0]          depth_clip;
    logic                    cfg_take;
    logic                    accept;
    logic                    emit;

    always_comb begin
        cfg_take   = cfg_load && (state != FLUSH);
        accept     = in_valid && !cfg_load && (state != FLUSH);
        emit       = accept && (state == RUN);
        // full depth wraps to raddr == wptr; the read sees the entry before this beat overwrites it
        raddr      = wptr - depth_reg[PTR_W-1:0];
        depth_clip = (depth > MAXD) ? MAXD : depth;
        state_nxt  = state;
        case (state)
            FLUSH: state_nxt = (depth_reg == '0) ? RUN : FILL;
            FILL: begin
                if (cfg_take)
                    state_nxt = FLUSH;
                else if (accept && ((fill_cnt + ONE) == depth_reg))
                    state_nxt = RUN;
            end
            RUN: begin
                if (cfg_take)
                    state_nxt = FLUSH;
            end
            default: state_nxt = FLUSH;
        endcase
        cfg_ack = (state == FLUSH);
        filling = (state != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RST_STATE;
            wptr      <= '0;
            fill_cnt  <= '0;
            depth_reg <= DEFD;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= emit;
            if (cfg_take)
                depth_reg <= depth_clip;
            if (state == FLUSH) begin
                wptr     <= '0;
                fill_cnt <= '0;
            end else if (accept) begin
                wptr <= wptr + W_ONE;
                if (state == FILL)
                    fill_cnt <= fill_cnt + ONE;
            end
            if (emit)
                data_out <= (depth_reg == '0) ? data_in : mem[raddr];
        end
    end

    // Buffer contents survive reset and flush; the refill gate keeps stale entries from being read.
    always_ff @(posedge clk) begin
        if (accept && !reset)
            mem[wptr] <= data_in;
    end

`ifdef DELAY_CTRL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || (state == FLUSH))
            out_count <= '0;
        else if (emit)
            out_count <= out_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl: a constant-expectation vector table plus a
// scoreboard that queues each beat's expected delayed sample from the history since the last flush.
module tb_delay_ctrl;
    localparam int W = 25;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic signed [W-1:0] data_in = '0;
    logic                in_valid = 1'b0;
    logic [4:0]          depth = '0;
    logic                cfg_load = 1'b0;
    logic signed [W-1:0] data_out;
    logic                out_valid;
    logic                cfg_ack;
    logic                filling;
`ifdef DELAY_CTRL_CNT_EN
    logic [15:0]         out_count;
`endif

    int checks = 0;
    int errors = 0;

    int                  m_d;
    int                  m_cnt;
    bit                  m_fl;
    logic signed [W-1:0] hist[$];
    logic signed [W-1:0] exp_q[$];
    logic signed [W-1:0] exp_last;

    typedef struct {
        logic                iv;
        logic signed [W-1:0] din;
        logic                cfg;
        logic [4:0]          dep;
        logic                eov;
        logic signed [W-1:0] edout;
        logic                eack;
        logic                efill;
    } vec_t;
    vec_t tbl[11];

    delay_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .in_valid (in_valid),
        .depth    (depth),
        .cfg_load (cfg_load),
        .data_out (data_out),
        .out_valid(out_valid),
        .cfg_ack  (cfg_ack),
        .filling  (filling)
`ifdef DELAY_CTRL_CNT_EN
        ,
        .out_count(out_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_d(input string name, input logic signed [W-1:0] act, input logic signed [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input bit iv, input bit cfg);
        reset    = 1'b1;
        in_valid = iv;
        data_in  = W'(999);
        cfg_load = cfg;
        depth    = 5'd3;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        m_d      = 7;
        m_cnt    = 0;
        m_fl     = 1'b0;
        hist.delete();
        exp_q.delete();
        exp_last = '0;
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_d("rst_data_out", data_out, '0);
        chk_b("rst_cfg_ack", cfg_ack, 1'b0);
        chk_b("rst_filling", filling, 1'b1);
    endtask

    task automatic drive(input bit iv, input logic signed [W-1:0] din, input bit cfg, input int dep);
        bit acc;
        bit eov;
        in_valid = iv;
        data_in  = din;
        cfg_load = cfg;
        depth    = dep[4:0];
        acc = iv && !m_fl && !cfg;
        eov = 1'b0;
        if (acc) begin
            hist.push_back(din);
            if (m_cnt >= m_d) begin
                eov = 1'b1;
                exp_q.push_back((m_d == 0) ? din : hist[m_cnt - m_d]);
            end
            m_cnt++;
        end
        if (m_fl) begin
            m_fl = 1'b0;
        end else if (cfg) begin
            m_fl  = 1'b1;
            m_d   = (dep > 16) ? 16 : dep;
            m_cnt = 0;
            hist.delete();
        end
        @(posedge clk);
        #1;
        chk_b("out_valid", out_valid, eov);
        if (eov)
            exp_last = exp_q.pop_front();
        chk_d("data_out", data_out, exp_last);
        chk_b("cfg_ack", cfg_ack, m_fl);
        chk_b("filling", filling, m_fl || (m_cnt < m_d));
    endtask

    initial begin
        // starts from reset (depth 7, FILL)
        tbl[0]  = '{1'b1, W'(100), 1'b1, 5'd0,  1'b0, W'(0),   1'b1, 1'b1};
        tbl[1]  = '{1'b1, W'(101), 1'b0, 5'd0,  1'b0, W'(0),   1'b0, 1'b0};
        tbl[2]  = '{1'b1, W'(102), 1'b0, 5'd0,  1'b1, W'(102), 1'b0, 1'b0};
        tbl[3]  = '{1'b0, W'(103), 1'b0, 5'd0,  1'b0, W'(102), 1'b0, 1'b0};
        tbl[4]  = '{1'b1, -W'(5),  1'b0, 5'd0,  1'b1, -W'(5),  1'b0, 1'b0};
        tbl[5]  = '{1'b1, W'(7),   1'b1, 5'd2,  1'b0, -W'(5),  1'b1, 1'b1};
        tbl[6]  = '{1'b1, W'(8),   1'b1, 5'd5,  1'b0, -W'(5),  1'b0, 1'b1};
        tbl[7]  = '{1'b1, W'(9),   1'b0, 5'd0,  1'b0, -W'(5),  1'b0, 1'b1};
        tbl[8]  = '{1'b1, W'(10),  1'b0, 5'd0,  1'b0, -W'(5),  1'b0, 1'b0};
        tbl[9]  = '{1'b1, W'(11),  1'b0, 5'd0,  1'b1, W'(9),   1'b0, 1'b0};
        tbl[10] = '{1'b1, W'(12),  1'b0, 5'd0,  1'b1, W'(10),  1'b0, 1'b0};

        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            in_valid = tbl[i].iv;
            data_in  = tbl[i].din;
            cfg_load = tbl[i].cfg;
            depth    = tbl[i].dep;
            @(posedge clk);
            #1;
            chk_b($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].eov);
            chk_d($sformatf("tbl%0d_data_out", i), data_out, tbl[i].edout);
            chk_b($sformatf("tbl%0d_cfg_ack", i), cfg_ack, tbl[i].eack);
            chk_b($sformatf("tbl%0d_filling", i), filling, tbl[i].efill);
        end

        // continuous stream at the reset depth
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 20; i++)
            drive(1'b1, W'(i), 1'b0, 0);

        // alternating valid at depth 7
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0)
                drive(1'b1, W'(i / 2 + 1), 1'b0, 0);
            else
                drive(1'b0, W'(0), 1'b0, 0);
        end

        // reset in RUN with a live beat and a config request; depth must come back to 7
        for (int i = 0; i < 3; i++)
            drive(1'b1, W'(50 + i), 1'b0, 0);
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 12; i++)
            drive(1'b1, W'(200 + i), 1'b0, 0);

        // oversize request clamps to full depth, including read-before-write
        drive(1'b1, W'(0), 1'b1, 31);
        for (int i = 0; i < 45; i++)
            drive(i % 7 != 3, -W'(i * 3 + 1), 1'b0, 0);

        // switch to depth 0 mid-stream
        drive(1'b1, W'(777), 1'b1, 0);
        for (int i = 0; i < 10; i++)
            drive(1'b1, W'(300 + i), 1'b0, 0);

        for (int i = 0; i < 300; i++)
            drive($urandom_range(3) != 0, W'($urandom), $urandom_range(15) == 0, int'($urandom_range(31)));

`ifdef DELAY_CTRL_CNT_EN
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 40; i++)
            drive(1'b1, W'(i), 1'b0, 0);
        chk_i("out_count_40", int'(out_count), 33);
        drive(1'b0, W'(0), 1'b1, 7);
        drive(1'b0, W'(0), 1'b0, 0);
        chk_i("out_count_flush", int'(out_count), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_ctrl.md
DELAY_CTRL -- requirements
Module: delay_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 25, meaning sample width (two's complement signed).
REQ-002 SHALL have parameter MAX_DEPTH, default 16, meaning buffer entries (power of two); PTR_W = log2(MAX_DEPTH).
REQ-003 SHALL have parameter DEF_DEPTH, default 7, meaning the delay depth loaded at reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port data_in  input  WIDTH signed  sample.
REQ-007 SHALL have port in_valid  input  1  data_in is a valid beat this cycle.
REQ-008 SHALL have port depth  input  PTR_W+1  requested delay in samples, 0..MAX_DEPTH.
REQ-009 SHALL have port cfg_load  input  1  single-cycle request to apply depth.
REQ-010 SHALL have port data_out  output  WIDTH signed  delayed sample, registered.
REQ-011 SHALL have port out_valid  output  1  data_out is a new valid beat, registered.
REQ-012 SHALL have port cfg_ack  output  1  one-cycle pulse when a new depth has been applied.
REQ-013 SHALL have port filling  output  1  high while in state FLUSH or FILL.

Function
REQ-014 SHALL delay by valid beats, not by cycles: the pointers advance only on accepted beats, where an accepted beat is in_valid=1 in state FILL or RUN.
REQ-015 SHALL store samples in a MAX_DEPTH-entry circular buffer; wptr increments modulo MAX_DEPTH per accepted beat; read address = (wptr - depth_reg) mod MAX_DEPTH.
REQ-016 SHALL read before write in the same cycle: with depth_reg = MAX_DEPTH, the read returns the old entry at wptr.
REQ-017 SHALL, for accepted beat k with depth_reg = D >= 1 and k >= D (0-based since the last flush), present sample k-D on data_out with out_valid=1 in the following cycle.
REQ-018 SHALL, with D = 0, present sample k itself on data_out one cycle after beat k.
REQ-019 SHALL otherwise hold out_valid=0, and data_out SHALL hold its last value.
REQ-020 SHALL implement states FLUSH, FILL and RUN.
REQ-021 State FLUSH: one cycle; wptr=0; fill_cnt=0; cfg_ack=1; inputs ignored; next state FILL if depth_reg > 0, else RUN.
REQ-022 State FILL: fill_cnt increments per accepted beat, with no output; on the beat where fill_cnt = depth_reg-1, next state RUN.
REQ-023 State RUN: every accepted beat produces an output per REQ-017; fill_cnt is frozen.
REQ-024 SHALL, on cfg_load=1 in any state, latch depth_reg = min(depth, MAX_DEPTH) and enter FLUSH next cycle; a beat in the same cycle is dropped and produces no output.
REQ-025 SHALL ignore cfg_load asserted during FLUSH, and SHALL NOT raise cfg_ack a second time for it.
REQ-026 SHALL drive filling = 1 in FLUSH and FILL, and 0 in RUN.
REQ-027 SHALL NOT clear buffer contents on flush; stale entries SHALL never be emitted, because output requires the refill per REQ-022.

Reset
REQ-028 SHALL, on reset=1 at a clk edge, set data_out=0, out_valid=0, cfg_ack=0, wptr=0, fill_cnt=0, depth_reg=DEF_DEPTH, and state=FILL (RUN if DEF_DEPTH=0).
REQ-029 SHALL let reset override cfg_load and in_valid in the same cycle; mid-operation reset discards all in-flight samples.
REQ-030 SHALL NOT reset the buffer memory.

Configuration
REQ-031 SHALL, when macro DELAY_CTRL_CNT_EN is defined, add output out_count [15:0], counting out_valid beats, wrapping at 0xFFFF->0, cleared by reset and by FLUSH.
REQ-032 SHALL, without DELAY_CTRL_CNT_EN, omit the out_count port and its logic; all other behaviour is identical.

Verification
REQ-033 Reset, then in_valid=1 continuously with data 1,2,3,...: out_valid first high one cycle after beat 7 (data 8 in); data_out=1, then 2,3,... each cycle.
REQ-034 Depth 7, in_valid toggled 1,0,1,0,... with data 1..20: outputs equal input-beat-minus-7 samples, and out_valid is high only on cycles following accepted beats.
REQ-035 cfg_load with depth=0 mid-stream: cfg_ack pulses next cycle, beat dropped; afterwards data_out equals data_in delayed one cycle with no fill gap.
REQ-036 cfg_load with depth=31: depth_reg=16, and sample -16 is emitted, including the read-before-write case at full depth.
REQ-037 Reset asserted during RUN with in_valid=1: next cycle out_valid=0 and data_out=0; 7 new beats are needed before the next out_valid.
REQ-038 With DELAY_CTRL_CNT_EN: 40 beats at depth 7 give out_count=33; a following cfg_load clears it to 0.
